ifmap_window_router: RTL and testbench

//  Multi-window successor to the single-shot memory kernel. It buffers an ifmap byte stream and gathers

---
 rtl/memory_kernel_pkg.sv | 15 +
 rtl/ifmap_buffer.sv | 24 ++
 rtl/ifmap_window_router.sv | 179 +++++++++++++++++
 tb/tb_ifmap_window_router.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_kernel_pkg.sv
// Shared types and default geometry for the ifmap window router.
package memory_kernel_pkg;

  localparam int unsigned DefDataWidth = 8;
  localparam int unsigned DefMaxWidth  = 9;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DRAIN,
    HOLD,
    DONE
  } route_state_t;

endpackage

// File: rtl/ifmap_buffer.sv
// 1W1R synchronous-read ifmap RAM; read data appears one cycle after the address.
module ifmap_buffer #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned Depth     = 64,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 writeEn,
  input  logic [AddrWidth-1:0] writeAddr,
  input  logic [DataWidth-1:0] writeData,
  input  logic [AddrWidth-1:0] readAddr,
  output logic [DataWidth-1:0] readData
);

  logic [DataWidth-1:0] mem [Depth];

  always_ff @(posedge clk) begin
    if (writeEn) begin
      mem[writeAddr] <= writeData;
    end
    readData <= mem[readAddr];
  end

endmodule

// File: rtl/ifmap_window_router.sv
// Gathers strided kernel windows from a buffered ifmap stream onto a lane bus.
// Optional border padding: define IFMAP_ZERO_PAD_EN to zero out-of-range elements instead of wrapping.
module ifmap_window_router
  import memory_kernel_pkg::*;
#(
  parameter int unsigned DataWidth  = DefDataWidth,
  parameter int unsigned Depth      = 64,
  parameter int unsigned MaxWidth   = DefMaxWidth,
  parameter int unsigned MaxWindows = 16,
  parameter int unsigned AddrWidth  = $clog2(Depth),
  parameter int unsigned CntWidth   = $clog2(MaxWindows + 1),
  parameter int unsigned WidthBits  = $clog2(MaxWidth + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          writeEn,
  input  logic [AddrWidth-1:0]          writeAddr,
  input  logic [DataWidth-1:0]          dataIn,
  input  logic                          routeEn,
  input  logic [AddrWidth-1:0]          startAddr,
  input  logic [WidthBits-1:0]          inputWidth,
  input  logic [AddrWidth-1:0]          stride,
  input  logic [CntWidth-1:0]           numWindows,
  output logic                          outValid,
  input  logic                          outReady,
  output logic [MaxWidth*DataWidth-1:0] dataOut,
  output logic [CntWidth-1:0]           winIdx,
  output logic                          busy,
  output logic                          finished,
  output logic                          writeErr
);

  localparam int unsigned AW1 = AddrWidth + 1;

  route_state_t         state;
  logic [AddrWidth-1:0] baseAddr;
  logic [AddrWidth-1:0] strideR;
  logic [WidthBits-1:0] widthR;
  logic [CntWidth-1:0]  numWinR;
  logic [WidthBits-1:0] kCnt;
  logic                 firstBubble;
  logic                 padQ;
  logic [DataWidth-1:0] lanes [MaxWidth];

  logic [AddrWidth:0]   rawAddr;
  logic [AddrWidth:0]   baseSum;
  logic [AddrWidth-1:0] readAddr;
  logic [AddrWidth-1:0] nextBase;
  logic [DataWidth-1:0] readData;
  logic [DataWidth-1:0] capData;
  logic                 padHit;
  logic [WidthBits-1:0] cmdWidth;
  logic [CntWidth-1:0]  cmdWin;
  logic                 bufWe;

  assign bufWe = writeEn && (state == IDLE);

  ifmap_buffer #(
    .DataWidth (DataWidth),
    .Depth     (Depth),
    .AddrWidth (AddrWidth)
  ) uBuffer (
    .clk       (clk),
    .writeEn   (bufWe),
    .writeAddr (writeAddr),
    .writeData (dataIn),
    .readAddr  (readAddr),
    .readData  (readData)
  );

  // Unwrapped element address; one extra bit so border detection sees the carry.
  assign rawAddr = {1'b0, baseAddr} + AW1'(kCnt);
  assign baseSum = {1'b0, baseAddr} + {1'b0, strideR};
  assign nextBase = (baseSum >= AW1'(Depth)) ? AddrWidth'(baseSum - AW1'(Depth))
                                             : baseSum[AddrWidth-1:0];

`ifdef IFMAP_ZERO_PAD_EN
  assign padHit   = (rawAddr >= AW1'(Depth));
  assign readAddr = rawAddr[AddrWidth-1:0];
`else
  assign padHit   = 1'b0;
  assign readAddr = (rawAddr >= AW1'(Depth)) ? AddrWidth'(rawAddr - AW1'(Depth))
                                             : rawAddr[AddrWidth-1:0];
`endif

  assign capData = padQ ? '0 : readData;

  always_comb begin
    cmdWidth = inputWidth;
    if (inputWidth == '0) begin
      cmdWidth = WidthBits'(1);
    end else if (inputWidth > WidthBits'(MaxWidth)) begin
      cmdWidth = WidthBits'(MaxWidth);
    end
    cmdWin = (numWindows == '0) ? CntWidth'(1) : numWindows;
  end

  always_comb begin
    dataOut = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      dataOut[i*DataWidth +: DataWidth] = lanes[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      baseAddr    <= '0;
      strideR     <= '0;
      widthR      <= WidthBits'(1);
      numWinR     <= CntWidth'(1);
      kCnt        <= '0;
      firstBubble <= 1'b0;
      padQ        <= 1'b0;
      outValid    <= 1'b0;
      winIdx      <= '0;
      busy        <= 1'b0;
      finished    <= 1'b0;
      writeErr    <= 1'b0;
      for (int i = 0; i < MaxWidth; i++) lanes[i] <= '0;
    end else begin
      writeErr <= writeEn && (state != IDLE);
      padQ     <= padHit;
      unique case (state)
        IDLE: begin
          if (routeEn) begin
            baseAddr    <= startAddr;
            widthR      <= cmdWidth;
            strideR     <= stride;
            numWinR     <= cmdWin;
            kCnt        <= '0;
            firstBubble <= 1'b1;
            winIdx      <= '0;
            finished    <= 1'b0;
            busy        <= 1'b1;
            for (int i = 0; i < MaxWidth; i++) lanes[i] <= '0;
            state       <= FETCH;
          end
        end
        FETCH: begin
          // The first window of a command spends one extra cycle before issuing reads.
          if (firstBubble) begin
            firstBubble <= 1'b0;
          end else begin
            if (kCnt != '0) lanes[kCnt - WidthBits'(1)] <= capData;
            if (kCnt == widthR - WidthBits'(1)) state <= DRAIN;
            kCnt <= kCnt + WidthBits'(1);
          end
        end
        DRAIN: begin
          lanes[widthR - WidthBits'(1)] <= capData;
          outValid <= 1'b1;
          state    <= HOLD;
        end
        HOLD: begin
          if (outReady) begin
            outValid <= 1'b0;
            if ((winIdx + CntWidth'(1)) < numWinR) begin
              winIdx   <= winIdx + CntWidth'(1);
              baseAddr <= nextBase;
              kCnt     <= '0;
              for (int i = 0; i < MaxWidth; i++) lanes[i] <= '0;
              state    <= FETCH;
            end else begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          finished <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifmap_window_router.sv
// Randomized self-checking bench for ifmap_window_router against a shadow-memory window model.
module tb_ifmap_window_router;

  localparam int DW = 8;
  localparam int DEPTH = 64;
  localparam int MW = 9;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           writeEn = 1'b0;
  logic [5:0]     writeAddr = '0;
  logic [7:0]     dataIn = '0;
  logic           routeEn = 1'b0;
  logic [5:0]     startAddr = '0;
  logic [3:0]     inputWidth = '0;
  logic [5:0]     stride = '0;
  logic [4:0]     numWindows = '0;
  logic           outValid;
  logic           outReady = 1'b0;
  logic [MW*DW-1:0] dataOut;
  logic [4:0]     winIdx;
  logic           busy;
  logic           finished;
  logic           writeErr;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] shadow [DEPTH];

  ifmap_window_router dut (
    .clk        (clk),
    .rst        (rst),
    .writeEn    (writeEn),
    .writeAddr  (writeAddr),
    .dataIn     (dataIn),
    .routeEn    (routeEn),
    .startAddr  (startAddr),
    .inputWidth (inputWidth),
    .stride     (stride),
    .numWindows (numWindows),
    .outValid   (outValid),
    .outReady   (outReady),
    .dataOut    (dataOut),
    .winIdx     (winIdx),
    .busy       (busy),
    .finished   (finished),
    .writeErr   (writeErr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Window j of a command: elements (start + j*stride) mod Depth + k for k < w.
  function automatic logic [MW*DW-1:0] exp_window(input int s, input int w, input int st,
                                                  input int j);
    logic [MW*DW-1:0] v;
    int base;
    int a;
    v = '0;
    base = (s + j * st) % DEPTH;
    for (int k = 0; k < w; k++) begin
      a = base + k;
`ifdef IFMAP_ZERO_PAD_EN
      v[k*8 +: 8] = (a >= DEPTH) ? 8'h00 : shadow[a];
`else
      v[k*8 +: 8] = shadow[a % DEPTH];
`endif
    end
    return v;
  endfunction

  function automatic int eff_w(input int w);
    return (w == 0) ? 1 : ((w > MW) ? MW : w);
  endfunction

  function automatic int eff_n(input int n);
    return (n == 0) ? 1 : n;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mem(input int a, input logic [7:0] d);
    writeEn = 1'b1;
    writeAddr = 6'(a);
    dataIn = d;
    step();
    writeEn = 1'b0;
    shadow[a] = d;
  endtask

  task automatic start_route(input int s, input int w, input int st, input int n);
    startAddr = 6'(s);
    inputWidth = 4'(w);
    stride = 6'(st);
    numWindows = 5'(n);
    routeEn = 1'b1;
    step();
    routeEn = 1'b0;
  endtask

  task automatic wait_valid(output int n, output bit to);
    n = 0;
    while (!outValid && n < 200) begin
      step();
      n++;
    end
    to = !outValid;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    vectors++; if (outValid !== 1'b0) begin miscompares++; $display("FAIL reset_outValid got=%b want=0", outValid); end
    vectors++; if (dataOut !== '0) begin miscompares++; $display("FAIL reset_dataOut got=%h want=0", dataOut); end
    vectors++; if (winIdx !== 5'd0) begin miscompares++; $display("FAIL reset_winIdx got=%0d want=0", winIdx); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got=%b want=0", busy); end
    vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL reset_finished got=%b want=0", finished); end
    vectors++; if (writeErr !== 1'b0) begin miscompares++; $display("FAIL reset_writeErr got=%b want=0", writeErr); end
    #2 rst = 1'b1;
    step();
  endtask

  task automatic test_single();
    int n;
    bit to;
    for (int a = 0; a < DEPTH; a++) write_mem(a, (a < 32) ? 8'(a) : 8'($urandom));
    outReady = 1'b1;
    start_route(0, 5, 0, 1);
    wait_valid(n, to);
    vectors++; if (to || n != 7) begin miscompares++; $display("FAIL single_latency got=%0d want=7", n); end
    vectors++; if (dataOut !== exp_window(0, 5, 0, 0)) begin miscompares++; $display("FAIL single_data got=%h want=%h", dataOut, exp_window(0, 5, 0, 0)); end
    vectors++; if (winIdx !== 5'd0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_idx_busy got=%0d/%b want=0/1", winIdx, busy); end
    step();
    vectors++; if (outValid !== 1'b0) begin miscompares++; $display("FAIL single_drop got=%b want=0", outValid); end
    step();
    vectors++; if (finished !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL single_finished got=%b/%b want=1/0", finished, busy); end
  endtask

  task automatic test_multi();
    int n;
    bit to;
    outReady = 1'b1;
    start_route(2, 3, 3, 4);
    vectors++; if (finished !== 1'b0) begin miscompares++; $display("FAIL multi_finished_clear got=%b want=0", finished); end
    for (int j = 0; j < 4; j++) begin
      wait_valid(n, to);
      vectors++; if (to || n != ((j == 0) ? 5 : 4)) begin miscompares++; $display("FAIL multi_latency win=%0d got=%0d want=%0d", j, n, (j == 0) ? 5 : 4); end
      vectors++; if (dataOut !== exp_window(2, 3, 3, j)) begin miscompares++; $display("FAIL multi_data win=%0d got=%h want=%h", j, dataOut, exp_window(2, 3, 3, j)); end
      vectors++; if (winIdx !== 5'(j)) begin miscompares++; $display("FAIL multi_winIdx got=%0d want=%0d", winIdx, j); end
      step();
    end
    step();
    vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL multi_finished got=%b want=1", finished); end
  endtask

  task automatic test_backpressure();
    int n;
    bit to;
    int s;
    int w;
    logic [MW*DW-1:0] hold;
    s = $urandom_range(0, 63);
    w = $urandom_range(1, 9);
    outReady = 1'b0;
    start_route(s, w, 7, 1);
    wait_valid(n, to);
    vectors++; if (to || dataOut !== exp_window(s, w, 7, 0)) begin miscompares++; $display("FAIL bp_data got=%h want=%h", dataOut, exp_window(s, w, 7, 0)); end
    hold = exp_window(s, w, 7, 0);
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++; if (outValid !== 1'b1 || dataOut !== hold || winIdx !== 5'd0) begin miscompares++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%0d want=1/%h/0", i, outValid, dataOut, winIdx, hold); end
    end
    outReady = 1'b1;
    step();
    vectors++; if (outValid !== 1'b0) begin miscompares++; $display("FAIL bp_accept got=%b want=0", outValid); end
    step();
    vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL bp_finished got=%b want=1", finished); end
  endtask

  task automatic test_wrap();
    int n;
    bit to;
    logic [MW*DW-1:0] want;
    outReady = 1'b1;
    start_route(62, 4, 0, 1);
    wait_valid(n, to);
    want = '0;
    want[7:0] = shadow[62];
    want[15:8] = shadow[63];
`ifndef IFMAP_ZERO_PAD_EN
    want[23:16] = shadow[0];
    want[31:24] = shadow[1];
`endif
    vectors++; if (to || dataOut !== want) begin miscompares++; $display("FAIL wrap_data got=%h want=%h", dataOut, want); end
    step();
    step();
  endtask

  task automatic test_write_busy();
    int n;
    bit to;
    logic [7:0] old;
    old = shadow[5];
    outReady = 1'b1;
    start_route(3, 9, 0, 1);
    writeEn = 1'b1;
    writeAddr = 6'd5;
    dataIn = ~old;
    step();
    writeEn = 1'b0;
    vectors++; if (writeErr !== 1'b1) begin miscompares++; $display("FAIL werr_pulse got=%b want=1", writeErr); end
    step();
    vectors++; if (writeErr !== 1'b0) begin miscompares++; $display("FAIL werr_single got=%b want=0", writeErr); end
    wait_valid(n, to);
    vectors++; if (to || dataOut !== exp_window(3, 9, 0, 0)) begin miscompares++; $display("FAIL werr_mem_kept got=%h want=%h", dataOut, exp_window(3, 9, 0, 0)); end
    step();
    step();
    vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL werr_finished got=%b want=1", finished); end
  endtask

  task automatic test_simul_write();
    int n;
    bit to;
    logic [7:0] nd;
    nd = ~shadow[10];
    outReady = 1'b1;
    writeEn = 1'b1;
    writeAddr = 6'd10;
    dataIn = nd;
    shadow[10] = nd;
    start_route(10, 2, 0, 1);
    writeEn = 1'b0;
    vectors++; if (writeErr !== 1'b0) begin miscompares++; $display("FAIL simw_noerr got=%b want=0", writeErr); end
    wait_valid(n, to);
    vectors++; if (to || dataOut[7:0] !== nd) begin miscompares++; $display("FAIL simw_lane0 got=%h want=%h", dataOut[7:0], nd); end
    vectors++; if (dataOut !== exp_window(10, 2, 0, 0)) begin miscompares++; $display("FAIL simw_data got=%h want=%h", dataOut, exp_window(10, 2, 0, 0)); end
    step();
    step();
  endtask

  task automatic test_reset_mid();
    int n;
    bit to;
    outReady = 1'b1;
    start_route(4, 3, 2, 4);
    for (int j = 0; j < 2; j++) begin
      wait_valid(n, to);
      vectors++; if (to || dataOut !== exp_window(4, 3, 2, j)) begin miscompares++; $display("FAIL rmid_data win=%0d got=%h want=%h", j, dataOut, exp_window(4, 3, 2, j)); end
      step();
    end
    step();
    step();
    vectors++; if (winIdx !== 5'd2 || busy !== 1'b1) begin miscompares++; $display("FAIL rmid_pre got=%0d/%b want=2/1", winIdx, busy); end
    #2 rst = 1'b0;
    #1;
    vectors++; if (outValid !== 1'b0 || dataOut !== '0 || winIdx !== 5'd0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_async got=%b/%h/%0d/%b want=0/0/0/0", outValid, dataOut, winIdx, busy); end
    step();
    #3 rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      vectors++; if (outValid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL rmid_quiet cyc=%0d got=%b/%b want=0/0", i, outValid, busy); end
    end
    start_route(20, 4, 5, 2);
    for (int j = 0; j < 2; j++) begin
      wait_valid(n, to);
      vectors++; if (to || dataOut !== exp_window(20, 4, 5, j) || winIdx !== 5'(j)) begin miscompares++; $display("FAIL rmid_after win=%0d got=%h/%0d want=%h/%0d", j, dataOut, winIdx, exp_window(20, 4, 5, j), j); end
      step();
    end
    step();
    vectors++; if (finished !== 1'b1) begin miscompares++; $display("FAIL rmid_finished got=%b want=1", finished); end
  endtask

  task automatic test_random();
    int s, w, st, nw, we, ne, n, c;
    bit r, acc;
    for (int it = 0; it < 25; it++) begin
      outReady = 1'b0;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
        write_mem($urandom_range(0, 63), 8'($urandom));
      end
      s = $urandom_range(0, 63);
      w = $urandom_range(0, 15);
      st = $urandom_range(0, 63);
      nw = $urandom_range(0, 5);
      we = eff_w(w);
      ne = eff_n(nw);
      start_route(s, w, st, nw);
      for (int j = 0; j < ne; j++) begin
        n = 0;
        while (!outValid && n < 300) begin
          outReady = 1'($urandom % 2);
          step();
          n++;
        end
        vectors++; if (!outValid || dataOut !== exp_window(s, we, st, j) || winIdx !== 5'(j)) begin miscompares++; $display("FAIL rand it=%0d win=%0d got=%b/%h/%0d want=1/%h/%0d", it, j, outValid, dataOut, winIdx, exp_window(s, we, st, j), j); end
        acc = 1'b0;
        c = 0;
        while (!acc && c < 50) begin
          r = 1'($urandom % 2);
          outReady = r;
          step();
          c++;
          acc = r;
        end
      end
      step();
      vectors++; if (finished !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL rand_done it=%0d got=%b/%b want=1/0", it, finished, busy); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_wrap();
    test_write_busy();
    test_simul_write();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
